// File: rtl/alu_pipe_if.sv
// Request/result handshake bundle for alu_pipe; slave modport is the ALU side.
// Request side is valid/ready; result side is valid/ready with results held until taken.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             invA;
  logic             invB;
  logic [4:0]       Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Cout;
  logic             Ofl;
  logic             err;

  modport master (
    output in_valid, A, B, Cin, invA, invB, Op, out_ready,
    input  in_ready, out_valid, Out, Cout, Ofl, err
  );

  modport slave (
    input  in_valid, A, B, Cin, invA, invB, Op, out_ready,
    output in_ready, out_valid, Out, Cout, Ofl, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU, latency 1 (multiply WIDTH*MUL_CYCLES_PER_BIT+1 with ALU_PIPE_MUL_EN); result
// held while out_ready=0, in_ready low while busy or stalled. ALU_PIPE_MUL_EN adds the multiplier.
module alu_pipe #(
  parameter int WIDTH              = 16,
  parameter int MUL_CYCLES_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);
  localparam int HW = WIDTH / 2;

  if (!(MUL_CYCLES_PER_BIT == 1 || MUL_CYCLES_PER_BIT == 2)) begin : g_bad_mul_cfg
    $error("alu_pipe: MUL_CYCLES_PER_BIT must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ofl_q, ofl_d;
  logic             err_q, err_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] aa, bb;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum;
  logic             add_cout, add_ofl;
  logic             seq, slt;
  logic [SW-1:0]    sh;
  logic [2*WIDTH-1:0] rot_l, rot_r;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] sc_out;
  logic             sc_err;

  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  assign aa       = bus.invA ? ~bus.A : bus.A;
  assign bb       = bus.invB ? ~bus.B : bus.B;
  assign add_full = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, bus.Cin};
  assign sum      = add_full[WIDTH-1:0];
  assign add_cout = add_full[WIDTH];
  assign add_ofl  = (aa[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != aa[WIDTH-1]);
  assign seq      = (sum == '0);
  assign slt      = sum[WIDTH-1] ^ add_ofl;
  assign sh       = bb[SW-1:0];

  always_comb begin
    rot_l  = {aa, aa} << sh;
    rot_r  = {aa, aa} >> sh;
    rev    = '0;
    for (int i = 0; i < WIDTH; i++) rev[i] = aa[WIDTH-1-i];
    sc_out = '0;
    sc_err = 1'b0;
    case (bus.Op)
      5'b00000: sc_out = rot_l[2*WIDTH-1:WIDTH];
      5'b00001: sc_out = aa << sh;
      5'b00010: sc_out = rot_r[WIDTH-1:0];
      5'b00011: sc_out = aa >> sh;
      5'b00100: sc_out = sum;
      5'b00101: sc_out = aa | bb;
      5'b00110: sc_out = aa ^ bb;
      5'b00111: sc_out = aa & bb;
      5'b01000: sc_out = rev;
      5'b01001: sc_out = {{(WIDTH-1){1'b0}}, seq};
      5'b01010: sc_out = {{(WIDTH-1){1'b0}}, slt};
      5'b01011: sc_out = {{(WIDTH-1){1'b0}}, slt | seq};
      5'b01100: sc_out = {{(WIDTH-1){1'b0}}, add_cout};
      5'b01101: sc_out = bb;
      5'b01110: sc_out = (aa << HW) | {{(WIDTH-HW){1'b0}}, bb[HW-1:0]};
      5'b01111: sc_out = aa;
      default:  sc_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int MUL_STEPS = WIDTH * MUL_CYCLES_PER_BIT;
  localparam int CW        = $clog2(MUL_STEPS);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               hi_q, hi_d;
  logic               is_mul, mul_step, mul_last;
  logic [WIDTH:0]     part;
  logic [2*WIDTH-1:0] acc_step;

  assign is_mul   = (bus.Op == 5'b10000) | (bus.Op == 5'b10001);
  assign mul_last = (cnt_q == CW'(MUL_STEPS - 1));
  // With two cycles per bit, only odd counts advance, so the last count still steps.
  assign mul_step = (MUL_CYCLES_PER_BIT == 1) | cnt_q[0];
  assign part     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {part, acc_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ofl_d   = ofl_q;
    err_d   = err_q;
`ifdef ALU_PIPE_MUL_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
`endif
    if (accept) begin
      cout_d  = add_cout;
      ofl_d   = add_ofl;
      state_d = HOLD;
      out_d   = sc_out;
      err_d   = sc_err;
`ifdef ALU_PIPE_MUL_EN
      if (is_mul) begin
        state_d = BUSY;
        out_d   = out_q;
        err_d   = 1'b0;
        cnt_d   = '0;
        acc_d   = {{WIDTH{1'b0}}, bb};
        mcand_d = aa;
        hi_d    = bus.Op[0];
      end
`endif
    end else if (state_q == HOLD) begin
      if (bus.out_ready) state_d = IDLE;
    end
`ifdef ALU_PIPE_MUL_EN
    else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
      if (mul_step) acc_d = acc_step;
      if (mul_last) begin
        state_d = HOLD;
        cnt_d   = '0;
        out_d   = hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ofl_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ofl_q   <= ofl_d;
      err_q   <= err_d;
`ifdef ALU_PIPE_MUL_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.Out       = out_q;
  assign bus.Cout      = cout_q;
  assign bus.Ofl       = ofl_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=16); multiply checks follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(16)) bus ();

  alu_pipe #(.WIDTH(16), .MUL_CYCLES_PER_BIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic ia, input logic ib, input logic [4:0] op);
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.invA     = ia;
    bus.invB     = ib;
    bus.Op       = op;
    bus.in_valid = 1'b1;
  endtask

  task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic ia, input logic ib, input logic [4:0] op,
                      input logic [15:0] exp_out, input logic exp_err);
    issue(a, b, cin, ia, ib, op);
    #1;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_out"}, {16'd0, bus.Out}, {16'd0, exp_out});
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic mul_run(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] op, input logic [15:0] exp_out);
    int n;
    issue(a, b, 1'b0, 1'b0, 1'b0, op);
    step();
    bus.in_valid = 1'b0;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      chk({tag, "_busy_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd17);
    chk({tag, "_out"}, {16'd0, bus.Out}, {16'd0, exp_out});
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.invA      = 1'b0;
    bus.invB      = 1'b0;
    bus.Op        = '0;
    step();
    step();
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out",       {16'd0, bus.Out},       32'd0);
    chk("rst_cout",      {31'd0, bus.Cout},      32'd0);
    chk("rst_ofl",       {31'd0, bus.Ofl},       32'd0);
    chk("rst_err",       {31'd0, bus.err},       32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run1("add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 5'b00100, 16'h8000, 1'b0);
    chk("add_ofl",  {31'd0, bus.Ofl},  32'd1);
    chk("add_cout", {31'd0, bus.Cout}, 32'd0);
    run1("sub", 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 5'b00100, 16'h0002, 1'b0);
    chk("sub_cout", {31'd0, bus.Cout}, 32'd1);
    chk("sub_ofl",  {31'd0, bus.Ofl},  32'd0);
    run1("ror",  16'h0001, 16'h0004, 1'b0, 1'b0, 1'b0, 5'b00010, 16'h1000, 1'b0);
    run1("rol",  16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 5'b00000, 16'h0003, 1'b0);
    run1("sll",  16'h00F0, 16'h0004, 1'b0, 1'b0, 1'b0, 5'b00001, 16'h0F00, 1'b0);
    run1("srl",  16'hF000, 16'h0014, 1'b0, 1'b0, 1'b0, 5'b00011, 16'h0F00, 1'b0);
    run1("or",   16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 5'b00101, 16'h0FFF, 1'b0);
    run1("xor",  16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 5'b00110, 16'h0FF0, 1'b0);
    run1("and",  16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 5'b00111, 16'hF000, 1'b0);
    run1("rev",  16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b01000, 16'h2C48, 1'b0);
    run1("seq1", 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 5'b01001, 16'h0001, 1'b0);
    run1("seq0", 16'h0005, 16'h0004, 1'b1, 1'b0, 1'b1, 5'b01001, 16'h0000, 1'b0);
    run1("slt",  16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1, 5'b01010, 16'h0001, 1'b0);
    run1("slt_ofl", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 5'b01010, 16'h0001, 1'b0);
    chk("slt_ofl_flag", {31'd0, bus.Ofl}, 32'd1);
    run1("slt_ge", 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 5'b01010, 16'h0000, 1'b0);
    run1("sle",  16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 5'b01011, 16'h0001, 1'b0);
    run1("sco",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 5'b01100, 16'h0001, 1'b0);
    run1("pack", 16'h00AB, 16'hFF34, 1'b0, 1'b0, 1'b0, 5'b01110, 16'hAB34, 1'b0);
    run1("inva", 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 5'b01111, 16'hFF00, 1'b0);
    run1("bad1f", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 5'b11111, 16'h0000, 1'b1);
    run1("bad12", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 5'b10010, 16'h0000, 1'b1);
    run1("passb", 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 5'b01101, 16'hBEEF, 1'b0);
    step();
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Stall the result, then release it in the same cycle a new request arrives.
    bus.out_ready = 1'b0;
    issue(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b01111);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_out",       {16'd0, bus.Out},       32'h1234);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      step();
    end
    issue(16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b01111);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_next_out",       {16'd0, bus.Out},       32'h5678);
    step();
    chk("bp_done_out_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef ALU_PIPE_MUL_EN
    mul_run("mulhu", 16'hFFFF, 16'h0003, 5'b10001, 16'h0002);
    mul_run("mul",   16'hFFFF, 16'h0003, 5'b10000, 16'hFFFD);
    step();
    issue(16'hFFFF, 16'h0003, 1'b0, 1'b0, 1'b0, 5'b10000);
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mulrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mulrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    seen = 0;
    repeat (25) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("mulrst_no_stale", seen, 32'd0);
`else
    run1("mul_unsup",   16'hFFFF, 16'h0003, 1'b0, 1'b0, 1'b0, 5'b10000, 16'h0000, 1'b1);
    run1("mulhu_unsup", 16'hFFFF, 16'h0003, 1'b0, 1'b0, 1'b0, 5'b10001, 16'h0000, 1'b1);
    step();
    seen = (bus.out_valid === 1'b1) ? 1 : 0;
    chk("unsup_drain", seen, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning datapath width in bits (power of two, 8..64).
REQ-002 The module SHALL have parameter MUL_CYCLES_PER_BIT, default 1, meaning iterative-multiplier cycles spent per operand bit (1 or 2).
REQ-003 The module SHALL have ports: clk  input  1  rising-edge clock; rst  input  1  reset, synchronous, active-high.
REQ-004 The module SHALL have ports: in_valid  input  1  request strobe; in_ready  output  1  request accepted when high with in_valid.
REQ-005 The module SHALL have ports: A, B  input  WIDTH  operands; Cin  input  1  adder carry-in; invA, invB  input  1  invert operand before use; Op  input  5  operation select.
REQ-006 The module SHALL have ports: out_valid  output  1  result present; out_ready  input  1  consumer accepts result; Out  output  WIDTH  result; Cout  output  1  adder carry; Ofl  output  1  signed overflow; err  output  1  unsupported Op.

Function
REQ-007 On acceptance (in_valid & in_ready) AA=invA?~A:A and BB=invB?~B:B SHALL be captured; all ops use AA/BB.
REQ-008 Op[4]=0 ops SHALL be single-cycle, with Out registered and out_valid high on the cycle after acceptance (latency 1).
REQ-009 Op 000xx (xx = 00 rol, 01 sll, 10 ror, 11 srl) SHALL shift AA by BB[$clog2(WIDTH)-1:0].
REQ-010 Op 00100 add SHALL output AA+BB+Cin; 00101 or, 00110 xor, 00111 and; 01000 bit-reverse of AA.
REQ-011 Op 01001 SEQ, 01010 SLT, 01011 SLE, 01100 SCO SHALL output a zero-extended 1-bit result computed from the sum AA+BB+Cin, with SLT = sum MSB xor Ofl, SEQ = (sum==0), SCO = carry-out.
REQ-012 Op 01101 SHALL output BB; 01110 SHALL output (AA<<WIDTH/2)|zero-extended BB[WIDTH/2-1:0]; 01111 SHALL output AA.
REQ-013 Cout and Ofl SHALL reflect the adder for every accepted op and be registered alongside Out; Ofl = (AA msb==BB msb)&(sum msb!=AA msb).
REQ-014 Op 10000 MUL SHALL output the low WIDTH bits and Op 10001 MULHU the high WIDTH bits of the unsigned product AA*BB.
REQ-015 Multiply SHALL be iterative shift-add, with out_valid asserted exactly WIDTH*MUL_CYCLES_PER_BIT+1 cycles after acceptance.
REQ-016 The state machine SHALL have states IDLE, BUSY (multiply iterating), and HOLD (out_valid=1 awaiting out_ready).
REQ-017 Transitions: IDLE->HOLD on single-cycle accept; IDLE->BUSY on multiply accept; BUSY->HOLD when the iteration counter reaches its terminal count; HOLD->IDLE on out_ready without a new accept; HOLD->HOLD with a new single-cycle accept; HOLD->BUSY with a new multiply accept.
REQ-018 in_ready SHALL equal (state==IDLE)|(state==HOLD & out_ready); in_ready SHALL be 0 throughout BUSY.
REQ-019 While out_valid=1 and out_ready=0, Out, Cout, Ofl, and err SHALL hold stable.
REQ-020 Simultaneous out_ready and accept in HOLD SHALL retire the old result and load the new one with no bubble for single-cycle ops.
REQ-021 Op values 10010..11111 SHALL complete single-cycle with Out=0 and err=1; err SHALL be 0 for all other ops.

Reset
REQ-022 While rst=1 at a clk edge, the state SHALL become IDLE, and out_valid, Out, Cout, Ofl, err, and the multiply counter and accumulator SHALL become 0.
REQ-023 in_ready SHALL be 0 while rst=1.
REQ-024 Reset asserted during BUSY SHALL abort the multiply, with no result ever presented.

Configuration
REQ-025 Macro ALU_PIPE_MUL_EN defined SHALL compile in the iterative multiplier and BUSY state per REQ-014..REQ-017.
REQ-026 Without ALU_PIPE_MUL_EN, Op 10000 and 10001 SHALL behave as unsupported (Out=0, err=1, latency 1), BUSY SHALL be unreachable, and no multiplier logic SHALL be present.

Verification
REQ-027 Add: WIDTH=16, A=16'h7FFF, B=16'h0001, Cin=0, Op=00100 -> next cycle Out=16'h8000, Ofl=1, Cout=0, out_valid=1.
REQ-028 Shift/pack: Op=00010 ror, A=16'h0001, B=16'h0004 -> Out=16'h1000; Op=01110, A=16'h00AB, B=16'hFF34 -> Out=16'hAB34.
REQ-029 Backpressure: accept 16'h1234 pass-A with out_ready=0 for 5 cycles -> Out stable at 16'h1234, in_ready=0; raise out_ready together with a new in_valid -> new result the next cycle, no bubble.
REQ-030 Multiply (macro on, MUL_CYCLES_PER_BIT=1): A=16'hFFFF, B=16'h0003, Op=10001 -> out_valid exactly 17 cycles later, Out=16'h0002; Op=10000 -> Out=16'hFFFD; in_ready=0 throughout.
REQ-031 Reset mid-multiply: assert rst at cycle 5 of BUSY -> out_valid=0, state IDLE, in_ready=1 the cycle after rst drops, no stale result.
REQ-032 Unsupported op: Op=11111 (and, with macro off, Op=10000) -> Out=0, err=1 after one cycle.
